// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage registers: state encoding, default widths
// and control-bit positions used when packing/unpacking ctrl at each instantiation site.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int PIPE_DATA_W = 128;
  localparam int PIPE_CTRL_W = 8;

  localparam int CTRL_REGWEN   = 0;
  localparam int CTRL_MEMW     = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_TRAPREQ  = 3;
  localparam int CTRL_IS_JALR  = 4;
  localparam int CTRL_IS_DIV   = 5;
  localparam int CTRL_WBSEL_LO = 6;
  localparam int CTRL_WBSEL_HI = 7;

  typedef struct packed {
    logic [1:0] wbsel;
    logic       is_div;
    logic       is_jalr;
    logic       trap_req;
    logic       mem_read;
    logic       mem_w;
    logic       reg_wen;
  } ctrl_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload+ctrl register with load enable; ctrl-clear beats load so a squash
// never leaves live control bits behind, while the payload is simply retained.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ld,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_ctrl <= '0;
    end else begin
      if (i_ld) begin
        r_data <= i_data;
      end
      if (i_clr) begin
        r_ctrl <= '0;
      end else if (i_ld) begin
        r_ctrl <= i_ctrl;
      end
    end
  end

  assign o_data = r_data;
  assign o_ctrl = r_ctrl;

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage, 1-cycle latency; optional 2-entry skid keeps in_ready registered,
// otherwise in_ready is combinational. Flush squashes held entries; stall cycles counted (saturating).
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = PIPE_DATA_W,
  parameter int CTRL_W  = PIPE_CTRL_W,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [1:0]        r_state;
  logic [1:0]        w_nxt_state;
  logic              r_in_rdy;
  logic [CNT_W-1:0]  r_stall;

  logic              w_out_vld;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_ld;
  logic              w_main_from_skid;
  logic              w_skid_ld;

  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_skid_data;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_main_din;
  logic [CTRL_W-1:0] w_main_cin;

  assign w_out_vld  = (r_state != ST_EMPTY);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = w_out_vld & out_ready;

  // Without a skid, r_in_rdy only gates in_ready low until the first edge after reset.
  assign in_ready = SKID_EN ? r_in_rdy : (r_in_rdy & (~w_out_vld | out_ready));

  always_comb begin
    w_nxt_state      = r_state;
    w_main_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    if (flush) begin
      w_nxt_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_nxt_state = ST_ONE;
            w_main_ld   = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_ld = 1'b1;
          end else if (w_in_fire && SKID_EN) begin
            w_nxt_state = ST_FULL;
            w_skid_ld   = 1'b1;
          end else if (w_out_fire) begin
            w_nxt_state = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_nxt_state      = ST_ONE;
            w_main_ld        = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_nxt_state = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_EMPTY;
      r_in_rdy <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_in_rdy <= SKID_EN ? (w_nxt_state != ST_FULL) : 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
    end else if (cnt_clr) begin
      r_stall <= '0;
    end else if (w_out_vld && !out_ready && (r_stall != {CNT_W{1'b1}})) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign w_main_din = w_main_from_skid ? w_skid_data : in_data;
  assign w_main_cin = w_main_from_skid ? w_skid_ctrl : in_ctrl;

  pipe_skid_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk    (clk),
    .rst    (reset),
    .i_ld   (w_main_ld),
    .i_clr  (flush),
    .i_data (w_main_din),
    .i_ctrl (w_main_cin),
    .o_data (w_main_data),
    .o_ctrl (w_main_ctrl)
  );

  if (SKID_EN) begin : g_skid
    pipe_skid_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_skid (
      .clk    (clk),
      .rst    (reset),
      .i_ld   (w_skid_ld),
      .i_clr  (flush),
      .i_data (in_data),
      .i_ctrl (in_ctrl),
      .o_data (w_skid_data),
      .o_ctrl (w_skid_ctrl)
    );
  end else begin : g_no_skid
    assign w_skid_data = '0;
    assign w_skid_ctrl = '0;
  end

  assign out_valid = w_out_vld;
  assign out_data  = w_main_data;
  assign out_ctrl  = w_out_vld ? w_main_ctrl : '0;
  assign occupancy = r_state;
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a skid and a no-skid instance share stimulus and are each
// compared every cycle against a queue-style model, plus directed scenarios with literal expectations.
module tb_pipe_skid_stage;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int CNTW = 4;
  localparam int CNT_MAX = 15;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          flush;
  logic          out_ready;
  logic          cnt_clr;

  logic            s_in_ready, s_out_valid;
  logic [DW-1:0]   s_out_data;
  logic [CW-1:0]   s_out_ctrl;
  logic [1:0]      s_occ;
  logic [CNTW-1:0] s_stall;

  logic            n_in_ready, n_out_valid;
  logic [DW-1:0]   n_out_data;
  logic [CW-1:0]   n_out_ctrl;
  logic [1:0]      n_occ;
  logic [CNTW-1:0] n_stall;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 0;

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1), .CNT_W(CNTW)) u_dut_skid (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
    .occupancy(s_occ), .cnt_clr(cnt_clr), .stall_cnt(s_stall)
  );

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b0), .CNT_W(CNTW)) u_dut_noskid (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(n_out_valid),
    .out_ready(out_ready), .out_data(n_out_data), .out_ctrl(n_out_ctrl),
    .occupancy(n_occ), .cnt_clr(cnt_clr), .stall_cnt(n_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: index 0 = skid instance (capacity 2), index 1 = no-skid instance (capacity 1).
  // Each holds an ordered list of {ctrl,data} entries, oldest at [0].
  int              m_n   [2] = '{0, 0};
  logic [CW+DW-1:0] m_e  [2][2];
  int              m_cnt [2] = '{0, 0};
  bit              m_ren [2] = '{0, 0};

  function automatic bit exp_rdy(input int k);
    if (!m_ren[k]) return 1'b0;
    if (k == 0) return (m_n[0] < 2);
    return (m_n[1] == 0) || out_ready;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_n[k]   = 0;
        m_cnt[k] = 0;
        m_ren[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit inf, outf;
        inf  = in_valid && exp_rdy(k);
        outf = (m_n[k] > 0) && out_ready;
        if (cnt_clr) m_cnt[k] = 0;
        else if ((m_n[k] > 0) && !out_ready && m_cnt[k] < CNT_MAX) m_cnt[k]++;
        if (outf) begin
          m_e[k][0] = m_e[k][1];
          m_n[k]--;
        end
        if (flush) m_n[k] = 0;
        else if (inf) begin
          m_e[k][m_n[k]] = {in_ctrl, in_data};
          m_n[k]++;
        end
        m_ren[k] = 1'b1;
      end
    end
  end

  logic [DW-1:0] got0 [$];
  int            max_occ0 = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        logic            a_rdy, a_vld;
        logic [DW-1:0]   a_dat;
        logic [CW-1:0]   a_ctl;
        logic [1:0]      a_occ;
        logic [CNTW-1:0] a_cnt;
        a_rdy = (k == 0) ? s_in_ready  : n_in_ready;
        a_vld = (k == 0) ? s_out_valid : n_out_valid;
        a_dat = (k == 0) ? s_out_data  : n_out_data;
        a_ctl = (k == 0) ? s_out_ctrl  : n_out_ctrl;
        a_occ = (k == 0) ? s_occ       : n_occ;
        a_cnt = (k == 0) ? s_stall     : n_stall;
        chk($sformatf("d%0d in_ready", k), a_rdy, exp_rdy(k));
        chk($sformatf("d%0d out_valid", k), a_vld, m_n[k] > 0);
        chk($sformatf("d%0d occupancy", k), a_occ, m_n[k]);
        chk($sformatf("d%0d stall_cnt", k), a_cnt, m_cnt[k]);
        if (m_n[k] > 0) begin
          chk($sformatf("d%0d out_data", k), a_dat, m_e[k][0][DW-1:0]);
          chk($sformatf("d%0d out_ctrl", k), a_ctl, m_e[k][0][CW+DW-1:DW]);
        end else begin
          chk($sformatf("d%0d out_ctrl idle", k), a_ctl, 0);
        end
      end
      if (s_occ > max_occ0) max_occ0 = s_occ;
      if (s_out_valid && out_ready) got0.push_back(s_out_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                     input bit ordy, input bit fl, input bit clr);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
    tick();
  endtask

  initial begin
    int rdy_pct;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    flush = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    #1 reset = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("in_ready low after release", s_in_ready, 0);
    tick();
    chk("in_ready high after first edge", s_in_ready, 1);

    // Back-to-back streaming with no back-pressure.
    got0.delete();
    max_occ0 = 0;
    for (int i = 1; i <= 8; i++) drv(1, i, 8'h5A, 1, 0, 0);
    repeat (2) drv(0, 0, 0, 1, 0, 0);
    chk("stream count", got0.size(), 8);
    for (int i = 0; i < 8 && i < got0.size(); i++) chk("stream order", got0[i], i + 1);
    chk("stream max occupancy", max_occ0, 1);
    chk("stream stall_cnt", s_stall, 0);

    // Three stall cycles during A,B,C.
    got0.delete();
    drv(1, 32'hA, 8'h01, 1, 0, 0);
    drv(1, 32'hB, 8'h02, 0, 0, 0);
    chk("bp occupancy full", s_occ, 2);
    chk("bp in_ready full", s_in_ready, 0);
    drv(1, 32'hC, 8'h03, 0, 0, 0);
    drv(1, 32'hC, 8'h03, 0, 0, 0);
    drv(1, 32'hC, 8'h03, 1, 0, 0);
    drv(1, 32'hC, 8'h03, 1, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    chk("bp stall_cnt", s_stall, 3);
    chk("bp count", got0.size(), 3);
    if (got0.size() == 3) begin
      chk("bp first", got0[0], 32'hA);
      chk("bp second", got0[1], 32'hB);
      chk("bp third", got0[2], 32'hC);
    end

    // Flush while full, with a live input of all-ones ctrl.
    drv(1, 32'h11, 8'h5A, 0, 0, 0);
    drv(1, 32'h22, 8'h5A, 0, 0, 0);
    chk("pre-flush occupancy", s_occ, 2);
    drv(1, 32'h33, 8'hFF, 0, 1, 0);
    chk("flush occupancy", s_occ, 0);
    chk("flush out_valid", s_out_valid, 0);
    chk("flush out_ctrl", s_out_ctrl, 0);
    chk("flush in_ready", s_in_ready, 1);
    drv(0, 0, 0, 1, 0, 0);
    chk("flush dropped entry", s_occ, 0);

    // Asynchronous reset while full.
    drv(1, 32'h44, 8'h5A, 0, 0, 0);
    drv(1, 32'h55, 8'h5A, 0, 0, 0);
    chk("pre-reset occupancy", s_occ, 2);
    reset = 1'b1;
    #1;
    chk("reset out_valid", s_out_valid, 0);
    chk("reset out_ctrl", s_out_ctrl, 0);
    chk("reset occupancy", s_occ, 0);
    chk("reset in_ready", s_in_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    in_valid = 1'b0;
    chk("reset in_ready before edge", s_in_ready, 0);
    tick();
    chk("reset in_ready after edge", s_in_ready, 1);

    // Saturation and clear.
    drv(0, 0, 0, 0, 0, 1);
    drv(1, 32'h66, 8'h5A, 0, 0, 0);
    repeat (20) drv(0, 0, 0, 0, 0, 0);
    chk("saturated stall_cnt", s_stall, 15);
    chk("noskid in_ready stalled", n_in_ready, 0);
    drv(0, 0, 0, 0, 0, 1);
    chk("cnt_clr beats stall", s_stall, 0);

    // No-skid reload on simultaneous consume and accept.
    in_valid  = 1'b1;
    in_data   = 32'h77;
    in_ctrl   = 8'h3C;
    out_ready = 1'b1;
    #1;
    chk("noskid in_ready comb", n_in_ready, 1);
    tick();
    chk("noskid reload occupancy", n_occ, 1);
    chk("noskid reload data", n_out_data, 32'h77);
    drv(0, 0, 0, 1, 1, 0);

    // Randomised traffic with varying downstream pressure.
    for (int c = 0; c < 3000; c++) begin
      rdy_pct = (c < 1000) ? 80 : (c < 2000) ? 40 : 10;
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      in_valid  = ($urandom_range(0, 99) < 70);
      in_data   = $urandom;
      in_ctrl   = 8'($urandom);
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      flush     = ($urandom_range(0, 29) == 0);
      cnt_clr   = ($urandom_range(0, 39) == 0);
      tick();
      if (got0.size() > 64) got0.delete();
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Parametrised pipeline-stage register for the RISC-V core. It generalises the fixed per-signal stage latches into one payload-width-agnostic stage with valid/ready handshake, stall back-pressure, synchronous flush with control-bit squashing, an optional 2-entry skid buffer, and a saturating stall-cycle counter. It is instantiated between ID/EX, EX/MEM and MEM/WB. Payload packing and unpacking happen at each instantiation site.

Parameters:
DATA_W, 128, payload bits held across the stage (ALU result, rs2, pc, instr, csr data, ...); never cleared by flush.
CTRL_W, 8, control bits (regWEn, MemW, memRead, trapReq, is_jalr, is_div, WBSel); forced to 0 on reset and flush.
SKID_EN, 1, 1 gives a 2-entry skid buffer with registered in_ready; 0 gives a single entry with combinational in_ready.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  stage clock
reset  in  1  asynchronous reset, active-high
in_valid  in  1  upstream has a valid entry
in_ready  out  1  stage can accept this cycle
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control bits
flush  in  1  synchronous squash of all held entries (trap or branch redirect)
out_valid  out  1  stage output valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  held payload
out_ctrl  out  CTRL_W  held control bits; 0 whenever out_valid=0
occupancy  out  2  entries held: 0, 1 or 2
cnt_clr  in  1  synchronous clear of stall_cnt
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (asynchronous, reset=1):
  - state EMPTY; main and skid ctrl = 0; data = 0; stall_cnt = 0; occupancy = 0; out_valid = 0.
  - in_ready = 0 while reset is high. It rises on the first clk edge after reset deasserts.
  - A reset mid-operation discards all entries immediately.
- States (2-bit): EMPTY, ONE (main valid), FULL (main and skid valid). occupancy = state encoding.
- Output always comes from the main slot. out_valid = (state != EMPTY). Latency is 1 cycle from in_fire into EMPTY to out_valid.
- SKID_EN=1: in_ready is registered and equals (next_state != FULL).
- Transitions when flush=0:
  - EMPTY: in_fire -> ONE; main <= in.
  - ONE: in_fire & out_fire -> ONE; main <= in.
  - ONE: in_fire & !out_fire -> FULL; skid <= in.
  - ONE: !in_fire & out_fire -> EMPTY.
  - FULL: out_fire -> ONE; main <= skid. in_ready = 0, so in_fire cannot occur in FULL.
- SKID_EN=0: in_ready = !out_valid | out_ready (combinational). FULL is unreachable. ONE with in_fire & out_fire reloads main.
- flush has highest priority below reset:
  - next state EMPTY; ctrl of both slots <= 0; data retained.
  - An in_fire in the same cycle is dropped.
  - An out_fire in the same cycle is still a valid consume by downstream.
  - in_ready next cycle = 1.
- Ordering: entries leave in arrival order. The skid never overtakes main.
- stall_cnt:
  - +1 on each cycle with out_valid & !out_ready.
  - Holds at 2^CNT_W-1 (saturates).
  - cnt_clr has priority over increment.
  - flush does not clear it.
- No X propagation: out_ctrl is driven 0 when EMPTY, even though data may be stale.

Decomposition:
- Shared package pipe_pkg:
  - state localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - per-stage CTRL_W/DATA_W constants and ctrl bit-index constants (CTRL_REGWEN, CTRL_MEMW, ...) used for packing.
- Sub-module pipe_skid_slot: one DATA_W+CTRL_W register with load enable, ctrl-clear and async reset. Instantiated twice (main and skid), skid only when SKID_EN=1.

Test Plan:
1. Reset: assert reset mid-stream with state FULL -> immediately out_valid=0, out_ctrl=0, occupancy=0. in_ready=0 until the first edge after release, then 1.
2. Streaming, SKID_EN=1, out_ready=1: push data 0x1..0x8 back-to-back -> out_data 0x1..0x8 in order one cycle later, occupancy stays 1, stall_cnt=0.
3. Back-pressure: drop out_ready for 3 cycles during a stream of A,B,C -> occupancy 1->2, in_ready=0 while FULL. After release, outputs A,B,C in order with none lost. stall_cnt=3.
4. Flush in FULL with in_valid=1, in_ctrl=0xFF -> next cycle occupancy=0, out_valid=0, out_ctrl=0x00, incoming entry dropped, in_ready=1.
5. Saturation, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15. Pulse cnt_clr concurrent with a stall -> stall_cnt=0.
6. SKID_EN=0: out_ready=0 with main valid -> in_ready=0 combinationally. out_ready=1 with in_valid=1 in the same cycle -> main reloaded, occupancy never reaches 2.
